// File: rtl/dac_sample_sched.sv
// Sample scheduler for the sigma-delta dac: FIFO-buffered PCM, one sample per OSR-cycle period.
// Optional macro DAC_SCHED_MIDSCALE_EN: load midscale instead of holding the last sample on underflow.
module dac_sample_sched #(
    parameter int RES   = 8,
    parameter int OSR   = 64,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           s_valid,
    input  logic [RES-1:0] s_data,
    output logic           s_ready,
    output logic           conv,
    output logic [RES-1:0] dac_in,
    output logic           busy,
    output logic           sample_tick,
    output logic           underflow,
    input  logic           clr_uf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(OSR);
    localparam logic [PW-1:0]  PH_LAST = PW'(OSR - 1);
    localparam logic [PW-1:0]  PH_PRE  = PW'(OSR - 2);
    localparam logic [RES-1:0] MID     = {1'b1, {(RES-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    logic [RES-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           full, empty, push, pop;

    state_t         state_q;
    logic [PW-1:0]  phase_q;
    logic           conv_q, busy_q, tick_q, uf_q;
    logic [RES-1:0] dac_q;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign s_ready = !full;
    assign push    = s_valid && !full;

    // Pops happen only when a new period starts with data available.
    always_comb begin
        pop = 1'b0;
        if (state_q == IDLE)
            pop = en && !empty;
        else
            pop = (phase_q == PH_LAST) && en && !empty;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            conv_q  <= 1'b0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            dac_q   <= '0;
            uf_q    <= 1'b0;
        end else begin
            // Clear first so a same-cycle underflow set wins.
            if (clr_uf)
                uf_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    phase_q <= '0;
                    tick_q  <= 1'b0;
                    if (en && !empty) begin
                        state_q <= RUN;
                        conv_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        dac_q   <= mem_q[rd_ptr_q];
                    end
                end
                RUN: begin
                    if (phase_q == PH_LAST) begin
                        phase_q <= '0;
                        tick_q  <= 1'b0;
                        if (!en) begin
                            state_q <= IDLE;
                            conv_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (!empty) begin
                            dac_q <= mem_q[rd_ptr_q];
                        end else begin
                            uf_q <= 1'b1;
`ifdef DAC_SCHED_MIDSCALE_EN
                            dac_q <= MID;
`endif
                        end
                    end else begin
                        phase_q <= phase_q + PW'(1);
                        tick_q  <= (phase_q == PH_PRE);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign conv        = conv_q;
    assign dac_in      = dac_q;
    assign busy        = busy_q;
    assign sample_tick = tick_q;
    assign underflow   = uf_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Directed bench for dac_sample_sched with RES=8, OSR=4, DEPTH=4.
// Honours DAC_SCHED_MIDSCALE_EN for the expected underflow substitute.
module tb_dac_sample_sched;

    localparam int RES   = 8;
    localparam int OSR   = 4;
    localparam int DEPTH = 4;

`ifdef DAC_SCHED_MIDSCALE_EN
    localparam logic [7:0] UF_VAL = 8'h80;
`else
    localparam logic [7:0] UF_VAL = 8'h55;
`endif

    logic           clk = 1'b0;
    logic           rst, en, s_valid, clr_uf;
    logic [RES-1:0] s_data;
    logic           s_ready, conv, busy, sample_tick, underflow;
    logic [RES-1:0] dac_in;

    int n_chk  = 0;
    int n_fail = 0;

    dac_sample_sched #(.RES(RES), .OSR(OSR), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .conv        (conv),
        .dac_in      (dac_in),
        .busy        (busy),
        .sample_tick (sample_tick),
        .underflow   (underflow),
        .clr_uf      (clr_uf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_s [3];
        exp_s[0] = 8'h10; exp_s[1] = 8'h20; exp_s[2] = 8'h30;

        // Reset with en and s_valid held high
        rst = 1'b1; en = 1'b1; s_valid = 1'b1; s_data = 8'hAA; clr_uf = 1'b0;
        step(); step();
        check("rst_conv", conv, 0);
        check("rst_dac", dac_in, 0);
        check("rst_busy", busy, 0);
        check("rst_tick", sample_tick, 0);
        check("rst_uf", underflow, 0);
        check("rst_ready", s_ready, 1);
        rst = 1'b0; s_valid = 1'b0;
        step();
        check("rst_nopush_conv", conv, 0);
        en = 1'b0;

        // Streaming three samples
        push1(8'h10); push1(8'h20); push1(8'h30);
        en = 1'b1;
        step();
        check("stream_busy", busy, 1);
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < OSR; c++) begin
                check("stream_dac", dac_in, exp_s[j]);
                check("stream_conv", conv, 1);
                check("stream_tick", sample_tick, (c == OSR-1) ? 1 : 0);
                check("stream_uf", underflow, 0);
                if (j == 2 && c == OSR-1) en = 1'b0;
                step();
            end
        end
        check("stream_stop_conv", conv, 0);
        check("stream_stop_busy", busy, 0);
        check("stream_hold_dac", dac_in, 8'h30);

        // Underflow, clear, and set-over-clear priority
        push1(8'h55);
        en = 1'b1;
        step();
        check("uf_start_dac", dac_in, 8'h55);
        step(); step(); step();
        check("uf_before", underflow, 0);
        step();
        check("uf_set", underflow, 1);
        check("uf_dac", dac_in, UF_VAL);
        check("uf_conv", conv, 1);
        clr_uf = 1'b1;
        step();
        clr_uf = 1'b0;
        check("uf_cleared", underflow, 0);
        step();
        clr_uf = 1'b1;
        step();
        check("uf_still_clr", underflow, 0);
        step();
        clr_uf = 1'b0;
        check("uf_set_priority", underflow, 1);
        en = 1'b0;
        step(); step(); step(); step();
        check("uf_stop_conv", conv, 0);
        clr_uf = 1'b1;
        step();
        clr_uf = 1'b0;
        check("uf_idle_clear", underflow, 0);

        // Stop mid-period, remaining entries retained
        push1(8'h61); push1(8'h62); push1(8'h63);
        en = 1'b1;
        step();
        check("stop_dac0", dac_in, 8'h61);
        step();
        en = 1'b0;
        step();
        check("stop_ph2_conv", conv, 1);
        step();
        check("stop_ph3_conv", conv, 1);
        check("stop_ph3_tick", sample_tick, 1);
        step();
        check("stop_conv_fall", conv, 0);
        check("stop_busy", busy, 0);
        check("stop_dac_hold", dac_in, 8'h61);
        en = 1'b1;
        step();
        check("stop_resume_dac", dac_in, 8'h62);
        check("stop_resume_conv", conv, 1);
        step(); step(); step(); step();
        check("stop_resume_dac2", dac_in, 8'h63);
        en = 1'b0;
        step(); step(); step(); step();
        check("stop_final_conv", conv, 0);
        check("stop_empty_ready", s_ready, 1);

        // Full FIFO rejects the fifth sample
        push1(8'hA1); push1(8'hA2); push1(8'hA3);
        check("full_ready3", s_ready, 1);
        push1(8'hA4);
        check("full_ready4", s_ready, 0);
        push1(8'hA5);
        check("full_ready5", s_ready, 0);
        en = 1'b1;
        step();
        check("full_play0", dac_in, 8'hA1);
        step(); step(); step(); step();
        check("full_play1", dac_in, 8'hA2);
        step(); step(); step(); step();
        check("full_play2", dac_in, 8'hA3);
        step(); step(); step(); step();
        check("full_play3", dac_in, 8'hA4);
        step(); step(); step();
        en = 1'b0;
        step();
        check("full_end_conv", conv, 0);
        en = 1'b1;
        step();
        check("full_no_fifth", conv, 0);
        check("full_no_fifth_uf", underflow, 0);
        en = 1'b0;

        // Reset during RUN, then push-to-start latency
        push1(8'h71); push1(8'h72); push1(8'h73);
        en = 1'b1;
        step();
        step(); step(); step(); step();
        check("mrst_dac1", dac_in, 8'h72);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_conv", conv, 0);
        check("mrst_dac", dac_in, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", s_ready, 1);
        step();
        check("mrst_flushed", conv, 0);
        push1(8'h7E);
        check("p2s_edgeN", conv, 0);
        step();
        check("p2s_conv", conv, 1);
        check("p2s_dac", dac_in, 8'h7E);
        en = 1'b0;
        step(); step(); step(); step();
        check("p2s_stop", conv, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
